// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA pixel fetcher slice.
//
// Contents:
//   DEF_H_PIXELS / DEF_V_LINES : default active resolution (640x480)
//   DEF_RGB_W                  : default packed r,g,b width
//   DEF_DEFAULT_RGB            : underflow colour at the default width
//   cnt_w()                    : bit width of a counter holding 0..n-1
//   occ_w()                    : bit width of an occupancy count 0..depth
package vga_pkg;

    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_V_LINES  = 480;
    localparam int DEF_RGB_W    = 3;

    localparam logic [DEF_RGB_W-1:0] DEF_DEFAULT_RGB = '1;

    // Never returns 0 so a counter that only ever holds 0 still has a legal width.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int occ_w(input int depth);
        return cnt_w(depth) + 1;
    endfunction

endpackage

// File: rtl/vga_pix_fifo.sv
// Synchronous fall-through FIFO used as the pixel prefetch buffer.
//
// Ports:
//   clk, reset_   : clock, asynchronous active-low reset
//   flush         : empties the FIFO; overrides push and pop
//   push, push_data : write one entry (ignored when full)
//   pop           : remove the head (ignored when empty)
//   head          : current head entry, valid whenever !empty
//   empty         : no entries stored
//   occupancy     : number of stored entries, 0..DEPTH
module vga_pix_fifo
    import vga_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_,
    input  logic                    flush,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head,
    output logic                    empty,
    output logic [occ_w(DEPTH)-1:0] occupancy
);

    localparam int PTR_W = cnt_w(DEPTH);
    localparam int OCC_W = occ_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && (count != OCC_W'(DEPTH));
    assign do_pop    = pop && (count != '0);
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign occupancy = count;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + OCC_W'(1);
            else if (do_pop && !do_push) count <= count - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vga_pixel_fetcher.sv
// Raster-order image pixel source for the VGA timing core. Walks the
// active area, issues synchronous image-memory reads (with optional
// integer upscaling), and prefetches returned pixels into a small FIFO
// that the timing core drains with its fetch strobe.
//
// Ports:
//   clk, reset_         : pixel clock, asynchronous active-low reset
//   i_frame_start       : restarts the raster, flushes the prefetch path
//   i_fetch_next_pixel  : consumer pops one pixel
//   o_pixel_rgb         : FIFO head, or DEFAULT_RGB when empty
//   o_pixel_valid       : FIFO not empty
//   o_mem_rd, o_mem_addr: image-memory read strobe and address
//   i_mem_data          : read data, one cycle after o_mem_rd
//   o_underflow         : sticky pop-while-empty flag, cleared on frame start
//   o_frame_done        : every address of the frame has been issued
//   i_pattern_sel       : (only with VGA_TEST_PATTERN_EN) colour bars instead of memory
//
// Build option: define VGA_TEST_PATTERN_EN to add the colour-bar test pattern.
module vga_pixel_fetcher
    import vga_pkg::*;
#(
    parameter int               H_PIXELS    = DEF_H_PIXELS,
    parameter int               V_LINES     = DEF_V_LINES,
    parameter int               RGB_W       = DEF_RGB_W,
    parameter int               SCALE_LOG2  = 0,
    parameter int               ADDR_W      = 17,
    parameter int               FIFO_DEPTH  = 4,
    parameter logic [RGB_W-1:0] DEFAULT_RGB = '1
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              i_frame_start,
    input  logic              i_fetch_next_pixel,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              i_pattern_sel,
`endif
    output logic [RGB_W-1:0]  o_pixel_rgb,
    output logic              o_pixel_valid,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [RGB_W-1:0]  i_mem_data,
    output logic              o_underflow,
    output logic              o_frame_done
);

    localparam int X_W       = cnt_w(H_PIXELS);
    localparam int Y_W       = cnt_w(V_LINES);
    localparam int S_W       = cnt_w(1 << SCALE_LOG2);
    localparam int OCC_W     = occ_w(FIFO_DEPTH);
    localparam int SCALE_MAX = (1 << SCALE_LOG2) - 1;
    localparam int SRC_W     = H_PIXELS >> SCALE_LOG2;

    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [S_W-1:0]    sx;
    logic [S_W-1:0]    sy;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row_base;
    logic              frame_done;
    logic              in_flight;
    logic              underflow;
    logic              issue;

    logic [RGB_W-1:0]  fifo_head;
    logic [RGB_W-1:0]  push_data;
    logic              fifo_empty;
    logic [OCC_W-1:0]  fifo_count;

    // Reserve a slot for the read in flight so a return can never find the FIFO full.
    assign issue = !frame_done &&
                   (({1'b0, fifo_count} + (OCC_W+1)'(in_flight)) < (OCC_W+1)'(FIFO_DEPTH));

    // col tracks x>>SCALE_LOG2 incrementally, so the address is a single add.
    assign o_mem_addr    = row_base + col;
    assign o_frame_done  = frame_done;
    assign o_underflow   = underflow;
    assign o_pixel_valid = !fifo_empty;
    assign o_pixel_rgb   = fifo_empty ? DEFAULT_RGB : fifo_head;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]       bar_idx;
    logic [RGB_W-1:0] bar_rgb;
    logic [RGB_W-1:0] pattern_rgb;
    logic             pattern_pending;

    assign bar_idx  = 3'((int'(x) * 8) / H_PIXELS);
    assign o_mem_rd = issue && !i_pattern_sel;
    assign push_data = pattern_pending ? pattern_rgb : i_mem_data;

    // Bar index bits are repeated across the pixel so any RGB_W gets distinct bars.
    always_comb begin
        bar_rgb = '0;
        for (int i = 0; i < RGB_W; i++) bar_rgb[i] = bar_idx[i % 3];
    end

    // The bar colour is captured at issue time so it lines up with the normal return slot.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pattern_rgb     <= '0;
            pattern_pending <= 1'b0;
        end else if (issue) begin
            pattern_rgb     <= bar_rgb;
            pattern_pending <= i_pattern_sel;
        end
    end
`else
    assign o_mem_rd  = issue;
    assign push_data = i_mem_data;
`endif

    vga_pix_fifo #(
        .WIDTH (RGB_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_    (reset_),
        .flush     (i_frame_start),
        .push      (in_flight && !i_frame_start),
        .push_data (push_data),
        .pop       (i_fetch_next_pixel && !i_frame_start),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .occupancy (fifo_count)
    );

    // Raster walk: frame start wins over everything; otherwise each issue
    // advances x/sx/col, and at end of line y/sy/row_base. row_base only
    // moves when a full group of repeated lines has been emitted.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            x          <= '0;
            y          <= '0;
            sx         <= '0;
            sy         <= '0;
            col        <= '0;
            row_base   <= '0;
            frame_done <= 1'b1;
            in_flight  <= 1'b0;
            underflow  <= 1'b0;
        end else if (i_frame_start) begin
            x          <= '0;
            y          <= '0;
            sx         <= '0;
            sy         <= '0;
            col        <= '0;
            row_base   <= '0;
            frame_done <= 1'b0;
            in_flight  <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            in_flight <= issue;
            if (i_fetch_next_pixel && fifo_empty) underflow <= 1'b1;
            if (issue) begin
                if (x == X_W'(H_PIXELS - 1)) begin
                    x   <= '0;
                    sx  <= '0;
                    col <= '0;
                    if (y == Y_W'(V_LINES - 1)) begin
                        y          <= '0;
                        sy         <= '0;
                        row_base   <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        y <= y + Y_W'(1);
                        if (sy == S_W'(SCALE_MAX)) begin
                            sy       <= '0;
                            row_base <= row_base + ADDR_W'(SRC_W);
                        end else begin
                            sy <= sy + S_W'(1);
                        end
                    end
                end else begin
                    x <= x + X_W'(1);
                    if (sx == S_W'(SCALE_MAX)) begin
                        sx  <= '0;
                        col <= col + ADDR_W'(1);
                    end else begin
                        sx <= sx + S_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetcher.sv
// Testbench for vga_pixel_fetcher. Two instances with an 8x4 raster and
// 8-bit pixels: dut0 unscaled, dut1 with 2x upscaling. Both get the same
// stimulus; sel picks which one's outputs the checks look at. Inputs are
// driven and outputs sampled on the falling edge.
module tb_vga_pixel_fetcher;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int RW = 8;
    localparam int AW = 6;
    localparam logic [RW-1:0] DEF_RGB = 8'hFF;

    logic          clk = 1'b0;
    logic          reset_ = 1'b0;
    logic          frame_start = 1'b0;
    logic          fetch = 1'b0;
    logic          sel = 1'b0;

    logic [RW-1:0] rgb0, rgb1, mem_data0, mem_data1;
    logic          valid0, valid1, rd0, rd1, uf0, uf1, done0, done1;
    logic [AW-1:0] addr0, addr1;

    logic [RW-1:0] obs_rgb;
    logic          obs_valid, obs_rd, obs_uf, obs_done;
    logic [AW-1:0] obs_addr;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vga_pixel_fetcher #(
        .H_PIXELS(H), .V_LINES(V), .RGB_W(RW), .SCALE_LOG2(0),
        .ADDR_W(AW), .FIFO_DEPTH(4), .DEFAULT_RGB(DEF_RGB)
    ) dut0 (
        .clk(clk), .reset_(reset_), .i_frame_start(frame_start),
        .i_fetch_next_pixel(fetch), .o_pixel_rgb(rgb0), .o_pixel_valid(valid0),
        .o_mem_rd(rd0), .o_mem_addr(addr0), .i_mem_data(mem_data0),
        .o_underflow(uf0), .o_frame_done(done0)
    );

    vga_pixel_fetcher #(
        .H_PIXELS(H), .V_LINES(V), .RGB_W(RW), .SCALE_LOG2(1),
        .ADDR_W(AW), .FIFO_DEPTH(4), .DEFAULT_RGB(DEF_RGB)
    ) dut1 (
        .clk(clk), .reset_(reset_), .i_frame_start(frame_start),
        .i_fetch_next_pixel(fetch), .o_pixel_rgb(rgb1), .o_pixel_valid(valid1),
        .o_mem_rd(rd1), .o_mem_addr(addr1), .i_mem_data(mem_data1),
        .o_underflow(uf1), .o_frame_done(done1)
    );

    assign obs_rgb   = sel ? rgb1   : rgb0;
    assign obs_valid = sel ? valid1 : valid0;
    assign obs_rd    = sel ? rd1    : rd0;
    assign obs_addr  = sel ? addr1  : addr0;
    assign obs_uf    = sel ? uf1    : uf0;
    assign obs_done  = sel ? done1  : done0;

    // Image memory contents: distinct, never equal to the underflow colour.
    function automatic logic [RW-1:0] mem_f(input int a);
        return RW'(a * 5 + 33);
    endfunction

    // Synchronous memory: data appears one cycle after the address.
    always @(posedge clk) begin
        mem_data0 <= mem_f(int'(addr0));
        mem_data1 <= mem_f(int'(addr1));
    end

    // Expected source address of the i-th output pixel for upscale 2**s.
    function automatic int exp_addr(input int i, input int s);
        int xx, yy;
        xx = i % H;
        yy = i / H;
        return ((yy >> s) * (H >> s)) + (xx >> s);
    endfunction

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (obs_rd !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd got=%b want=0", obs_rd); end
        total++; if (obs_addr !== '0) begin bad++; $display("[TB] FAIL reset_addr got=%0d want=0", obs_addr); end
        total++; if (obs_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", obs_valid); end
        total++; if (obs_rgb !== DEF_RGB) begin bad++; $display("[TB] FAIL reset_rgb got=%h want=%h", obs_rgb, DEF_RGB); end
        total++; if (obs_uf !== 1'b0) begin bad++; $display("[TB] FAIL reset_underflow got=%b want=0", obs_uf); end
        total++; if (obs_done !== 1'b1) begin bad++; $display("[TB] FAIL reset_frame_done got=%b want=1", obs_done); end
    endtask

    // Full frame with the consumer popping whenever a pixel is available.
    task automatic test_raster(input int s);
        int addr_idx = 0;
        int pix_idx = 0;
        bit started = 0;
        int cyc = 0;
        sel = (s != 0);
        pulse_frame_start();
        total++; if (obs_done !== 1'b0) begin bad++; $display("[TB] FAIL raster%0d_done_clear got=%b want=0", s, obs_done); end
        while ((addr_idx < H*V || pix_idx < H*V) && cyc < 80) begin
            if (obs_rd === 1'b1) begin
                total++;
                if (addr_idx >= H*V || int'(obs_addr) !== exp_addr(addr_idx, s)) begin
                    bad++;
                    $display("[TB] FAIL raster%0d_addr idx=%0d got=%0d want=%0d", s, addr_idx, obs_addr, exp_addr(addr_idx, s));
                end
                addr_idx++;
            end
            if (obs_valid === 1'b1) begin
                started = 1;
                total++;
                if (obs_rgb !== mem_f(exp_addr(pix_idx, s))) begin
                    bad++;
                    $display("[TB] FAIL raster%0d_pixel idx=%0d got=%h want=%h", s, pix_idx, obs_rgb, mem_f(exp_addr(pix_idx, s)));
                end
                pix_idx++;
            end else if (started && pix_idx < H*V) begin
                total++; bad++;
                $display("[TB] FAIL raster%0d_gap idx=%0d got=valid0 want=valid1", s, pix_idx);
            end
            fetch = obs_valid;
            @(negedge clk);
            cyc++;
        end
        total++;
        if (addr_idx != H*V || pix_idx != H*V) begin
            bad++;
            $display("[TB] FAIL raster%0d_count got=%0d/%0d want=%0d", s, addr_idx, pix_idx, H*V);
        end
        fetch = 1'b0;
        total++; if (obs_done !== 1'b1) begin bad++; $display("[TB] FAIL raster%0d_done got=%b want=1", s, obs_done); end
        total++; if (obs_valid !== 1'b0) begin bad++; $display("[TB] FAIL raster%0d_drained got=%b want=0", s, obs_valid); end
        for (int k = 0; k < 3; k++) begin
            total++; if (obs_rd !== 1'b0) begin bad++; $display("[TB] FAIL raster%0d_idle_rd got=%b want=0", s, obs_rd); end
            @(negedge clk);
        end
        total++; if (obs_uf !== 1'b0) begin bad++; $display("[TB] FAIL raster%0d_underflow got=%b want=0", s, obs_uf); end
    endtask

    // Without pops only FIFO_DEPTH reads go out; one pop frees exactly one read.
    task automatic test_backpressure();
        int reads = 0;
        sel = 1'b0;
        pulse_frame_start();
        for (int k = 0; k < 10; k++) begin
            if (obs_rd === 1'b1) reads++;
            @(negedge clk);
        end
        total++; if (reads != 4) begin bad++; $display("[TB] FAIL bp_reads got=%0d want=4", reads); end
        total++; if (obs_rd !== 1'b0) begin bad++; $display("[TB] FAIL bp_stalled got=%b want=0", obs_rd); end
        total++; if (obs_rgb !== mem_f(0)) begin bad++; $display("[TB] FAIL bp_head got=%h want=%h", obs_rgb, mem_f(0)); end
        fetch = 1'b1;
        @(negedge clk);
        fetch = 1'b0;
        total++; if (obs_rgb !== mem_f(1)) begin bad++; $display("[TB] FAIL bp_head_after_pop got=%h want=%h", obs_rgb, mem_f(1)); end
        reads = 0;
        for (int k = 0; k < 6; k++) begin
            if (obs_rd === 1'b1) begin
                reads++;
                total++; if (obs_addr !== AW'(4)) begin bad++; $display("[TB] FAIL bp_new_addr got=%0d want=4", obs_addr); end
            end
            @(negedge clk);
        end
        total++; if (reads != 1) begin bad++; $display("[TB] FAIL bp_refill_reads got=%0d want=1", reads); end
    endtask

    // Pop before any data: sticky flag, default colour, no pixel lost.
    task automatic test_underflow();
        sel = 1'b0;
        pulse_frame_start();
        total++; if (obs_addr !== '0) begin bad++; $display("[TB] FAIL uf_first_addr got=%0d want=0", obs_addr); end
        fetch = 1'b1;
        @(negedge clk);
        fetch = 1'b0;
        total++; if (obs_uf !== 1'b1) begin bad++; $display("[TB] FAIL uf_set got=%b want=1", obs_uf); end
        total++; if (obs_rgb !== DEF_RGB) begin bad++; $display("[TB] FAIL uf_rgb got=%h want=%h", obs_rgb, DEF_RGB); end
        total++; if (obs_addr !== AW'(1)) begin bad++; $display("[TB] FAIL uf_no_skip_addr got=%0d want=1", obs_addr); end
        @(negedge clk);
        total++; if (obs_rgb !== mem_f(0)) begin bad++; $display("[TB] FAIL uf_first_pixel got=%h want=%h", obs_rgb, mem_f(0)); end
        repeat (3) @(negedge clk);
        total++; if (obs_uf !== 1'b1) begin bad++; $display("[TB] FAIL uf_sticky got=%b want=1", obs_uf); end
        pulse_frame_start();
        total++; if (obs_uf !== 1'b0) begin bad++; $display("[TB] FAIL uf_cleared got=%b want=0", obs_uf); end
    endtask

    // Restart mid-line with a read in flight and a simultaneous pop.
    task automatic test_restart_mid_line();
        sel = 1'b0;
        pulse_frame_start();
        for (int k = 0; k < 6; k++) begin
            fetch = obs_valid;
            @(negedge clk);
        end
        total++; if (obs_rd !== 1'b1 || obs_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL rs_pre_state got=rd%b/v%b want=rd1/v1", obs_rd, obs_valid);
        end
        frame_start = 1'b1;
        fetch = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        fetch = 1'b0;
        total++; if (obs_valid !== 1'b0) begin bad++; $display("[TB] FAIL rs_flushed got=%b want=0", obs_valid); end
        total++; if (obs_addr !== '0) begin bad++; $display("[TB] FAIL rs_addr got=%0d want=0", obs_addr); end
        total++; if (obs_rd !== 1'b1) begin bad++; $display("[TB] FAIL rs_rd got=%b want=1", obs_rd); end
        total++; if (obs_done !== 1'b0 || obs_uf !== 1'b0) begin
            bad++; $display("[TB] FAIL rs_flags got=done%b/uf%b want=done0/uf0", obs_done, obs_uf);
        end
        @(negedge clk);
        total++; if (obs_valid !== 1'b0) begin bad++; $display("[TB] FAIL rs_stale_squashed got=%b want=0", obs_valid); end
        @(negedge clk);
        total++; if (obs_valid !== 1'b1 || obs_rgb !== mem_f(0)) begin
            bad++; $display("[TB] FAIL rs_first_pixel got=v%b/%h want=v1/%h", obs_valid, obs_rgb, mem_f(0));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        reset_ = 1'b1;
        @(negedge clk);
        test_raster(0);
        test_raster(1);
        test_backpressure();
        test_underflow();
        test_restart_mid_line();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
